// File: rtl/vote_round_controller.sv
`default_nettype none
// vote_round_controller: gathers one vote per voter each round and presents the 2-of-3 majority
// on a val/rdy port. Define VOTE_ROUND_TIMEOUT_EN to close incomplete rounds after p_timeout cycles.
module vote_round_controller #(
  parameter int p_timeout = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] vote_val,
  input  logic [2:0] vote_bit,
  output logic [2:0] vote_rdy,
  output logic       result_val,
  output logic       result,
  input  logic       result_rdy,
  output logic       result_timeout
);

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_RESULT  = 1'b1;

  logic [0:0] state_q, state_d;
  logic [2:0] rcvd_q, rcvd_d;
  logic [2:0] vbits_q, vbits_d;
  logic       result_q, result_d;
  logic [2:0] fire;
  logic [2:0] merged_rcvd;
  logic [2:0] merged_bits;

  function automatic logic maj3(input logic [2:0] b);
    return (b[0] & b[1]) | (b[1] & b[2]) | (b[0] & b[2]);
  endfunction

  assign vote_rdy    = (state_q == ST_COLLECT) ? ~rcvd_q : 3'b000;
  assign result_val  = (state_q == ST_RESULT);
  assign result      = result_q;
  assign fire        = vote_val & vote_rdy;
  assign merged_rcvd = rcvd_q | fire;
  // Unreceived positions stay 0 in vbits, so a timed-out round counts missing votes as 0.
  assign merged_bits = (vbits_q & ~fire) | (vote_bit & fire);

`ifdef VOTE_ROUND_TIMEOUT_EN
  localparam logic [3:0] TIMEOUT_CNT = 4'(p_timeout);

  logic [3:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  assign result_timeout = timeout_q;
`else
  logic unused_cfg;
  assign unused_cfg     = (p_timeout > 0);
  assign result_timeout = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    rcvd_d   = rcvd_q;
    vbits_d  = vbits_q;
    result_d = result_q;
`ifdef VOTE_ROUND_TIMEOUT_EN
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
`endif
    case (state_q)
      ST_COLLECT: begin
        rcvd_d  = merged_rcvd;
        vbits_d = merged_bits;
`ifdef VOTE_ROUND_TIMEOUT_EN
        // cnt stays 0 until the round's first vote, so an idle round never times out.
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q + 4'd1;
        end else if (|fire) begin
          cnt_d = 4'd1;
        end
`endif
        if (merged_rcvd == 3'b111) begin
          result_d = maj3(merged_bits);
          state_d  = ST_RESULT;
`ifdef VOTE_ROUND_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
        end
`ifdef VOTE_ROUND_TIMEOUT_EN
        else if (cnt_q == TIMEOUT_CNT) begin
          result_d  = maj3(merged_bits);
          timeout_d = 1'b1;
          state_d   = ST_RESULT;
        end
`endif
      end
      default: begin
        if (result_rdy) begin
          state_d = ST_COLLECT;
          rcvd_d  = 3'b000;
          vbits_d = 3'b000;
`ifdef VOTE_ROUND_TIMEOUT_EN
          cnt_d = 4'd0;
`endif
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_COLLECT;
      rcvd_q   <= 3'b000;
      vbits_q  <= 3'b000;
      result_q <= 1'b0;
`ifdef VOTE_ROUND_TIMEOUT_EN
      cnt_q     <= 4'd0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rcvd_q   <= rcvd_d;
      vbits_q  <= vbits_d;
      result_q <= result_d;
`ifdef VOTE_ROUND_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vote_round_controller.sv
`default_nettype none
// Scoreboard bench for vote_round_controller: stimulus pushes expected results, a monitor pops them.
module tb_vote_round_controller;

  localparam int P_TIMEOUT = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] vote_val;
  logic [2:0] vote_bit;
  logic [2:0] vote_rdy;
  logic       result_val;
  logic       result;
  logic       result_rdy;
  logic       result_timeout;

  typedef struct packed {
    logic        res;
    logic        to;
    int unsigned rise;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int unsigned rise_cyc = 0;
  logic        prev_val = 1'b0;
  int          checks = 0;
  int          failures = 0;

  vote_round_controller #(.p_timeout(P_TIMEOUT)) dut (
    .clk            (clk),
    .reset          (reset),
    .vote_val       (vote_val),
    .vote_bit       (vote_bit),
    .vote_rdy       (vote_rdy),
    .result_val     (result_val),
    .result         (result),
    .result_rdy     (result_rdy),
    .result_timeout (result_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Present inputs for the current cycle, then return #1 after the edge that samples them.
  task automatic drive(input logic [2:0] v, input logic [2:0] b, input logic r);
    vote_val   = v;
    vote_bit   = b;
    result_rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_result(input logic res, input logic to, input int unsigned rise);
    exp_t e;
    e.res  = res;
    e.to   = to;
    e.rise = rise;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (result_val && !prev_val) rise_cyc = cyc;
    if (result_val && result_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result: got result=%0b timeout=%0b with none expected", result, result_timeout);
      end else begin
        e = exp_q.pop_front();
        chk("result", {31'd0, result}, {31'd0, e.res});
        chk("result_timeout", {31'd0, result_timeout}, {31'd0, e.to});
        chk("result_latency", rise_cyc, e.rise);
      end
    end
    prev_val = result_val;
  end

  logic [2:0] sim_bits [4] = '{3'b011, 3'b001, 3'b000, 3'b111};
  logic       sim_res  [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    reset      = 1'b0;
    vote_val   = 3'b111;
    vote_bit   = 3'b011;
    result_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_vote_rdy", {29'd0, vote_rdy}, 32'h7);
    chk("reset_result_val", {31'd0, result_val}, 32'h0);
    chk("reset_result", {31'd0, result}, 32'h0);
    chk("reset_timeout", {31'd0, result_timeout}, 32'h0);
    reset = 1'b1;

    // Simultaneous votes, each followed by a handoff cycle offering votes that must be refused.
    for (int i = 0; i < 4; i++) begin
      expect_result(sim_res[i], 1'b0, cyc + 1);
      drive(3'b111, sim_bits[i], 1'b0);
      chk("sim_vote_rdy_busy", {29'd0, vote_rdy}, 32'h0);
      chk("sim_result_val", {31'd0, result_val}, 32'h1);
      drive(3'b111, ~sim_bits[i], 1'b1);
      chk("handoff_vote_rdy", {29'd0, vote_rdy}, 32'h7);
      chk("handoff_result_val", {31'd0, result_val}, 32'h0);
    end

    // Staggered votes with a rejected duplicate from voter 0.
    drive(3'b001, 3'b001, 1'b0);
    chk("stag_vote_rdy", {29'd0, vote_rdy}, 32'h6);
    drive(3'b001, 3'b000, 1'b0);
    drive(3'b100, 3'b000, 1'b0);
    chk("stag_vote_rdy2", {29'd0, vote_rdy}, 32'h2);
    drive(3'b000, 3'b000, 1'b0);
    expect_result(1'b1, 1'b0, cyc + 1);
    drive(3'b010, 3'b010, 1'b0);

    // Backpressure: result held while new votes are offered.
    for (int i = 0; i < 5; i++) begin
      chk("bp_result_val", {31'd0, result_val}, 32'h1);
      chk("bp_result", {31'd0, result}, 32'h1);
      chk("bp_vote_rdy", {29'd0, vote_rdy}, 32'h0);
      drive(3'b111, 3'b000, 1'b0);
    end
    drive(3'b111, 3'b000, 1'b1);
    chk("bp_release_val", {31'd0, result_val}, 32'h0);
    chk("bp_release_rdy", {29'd0, vote_rdy}, 32'h7);

`ifdef VOTE_ROUND_TIMEOUT_EN
    // Timeout: two votes in cycle F, result_val in F+P_TIMEOUT+1.
    expect_result(1'b1, 1'b1, cyc + P_TIMEOUT + 1);
    drive(3'b011, 3'b011, 1'b0);
    repeat (P_TIMEOUT) drive(3'b000, 3'b000, 1'b0);
    chk("to_result_val", {31'd0, result_val}, 32'h1);
    drive(3'b000, 3'b000, 1'b1);
    expect_result(1'b0, 1'b1, cyc + P_TIMEOUT + 1);
    drive(3'b011, 3'b001, 1'b0);
    repeat (P_TIMEOUT) drive(3'b000, 3'b000, 1'b0);
    drive(3'b000, 3'b000, 1'b1);
`else
    // Without the timeout feature an incomplete round waits indefinitely.
    drive(3'b011, 3'b011, 1'b0);
    repeat (20) drive(3'b000, 3'b000, 1'b1);
    chk("wait_result_val", {31'd0, result_val}, 32'h0);
    chk("wait_vote_rdy", {29'd0, vote_rdy}, 32'h4);
    expect_result(1'b1, 1'b0, cyc + 1);
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b000, 3'b000, 1'b1);
`endif

    // Third vote lands exactly in the timeout cycle: completion wins.
    expect_result(1'b1, 1'b0, cyc + P_TIMEOUT + 1);
    drive(3'b011, 3'b001, 1'b0);
    repeat (P_TIMEOUT - 1) drive(3'b000, 3'b000, 1'b0);
    drive(3'b100, 3'b100, 1'b0);
    drive(3'b000, 3'b000, 1'b1);

    // Mid-round reset discards two latched votes.
    drive(3'b011, 3'b011, 1'b0);
    reset = 1'b0;
    #1;
    chk("mid_reset_vote_rdy", {29'd0, vote_rdy}, 32'h7);
    chk("mid_reset_result_val", {31'd0, result_val}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (P_TIMEOUT + 3) drive(3'b000, 3'b000, 1'b1);
    chk("post_reset_result_val", {31'd0, result_val}, 32'h0);
    chk("post_reset_vote_rdy", {29'd0, vote_rdy}, 32'h7);
    expect_result(1'b0, 1'b0, cyc + 1);
    drive(3'b111, 3'b100, 1'b0);
    drive(3'b000, 3'b000, 1'b1);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) drive(3'b000, 3'b000, 1'b1);
    chk("scoreboard_drained", exp_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vote_round_controller.md
# vote_round_controller

Round-based controller that shares a 3-input pair/triple (at-least-two-of-three) vote evaluation among three independent voters. It collects one vote bit from each voter through per-voter val/rdy handshakes, evaluates the majority once the round is complete, and holds the result on a val/rdy output port until it is consumed. It then opens the next round. It sits between three requester blocks and a downstream consumer, and the pair/triple function is its combinational core.

## Interface
- p_timeout, 8, cycles allowed per round after its first accepted vote; legal range 2..15; used only when the timeout feature is compiled in.

- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately, independent of clk.
- vote_val  in  3  bit i means voter i presents a vote this cycle.
- vote_bit  in  3  bit i is voter i's vote value; sampled only when vote_val[i] & vote_rdy[i].
- vote_rdy  out  3  bit i means the controller accepts voter i's vote this cycle.
- result_val  out  1  result is valid.
- result  out  1  1 when at least two of the three latched votes are 1.
- result_rdy  in  1  consumer accepts the result.
- result_timeout  out  1  round closed by timeout rather than completion; constant 0 when the feature is compiled out.

## Operation
- State: FSM {COLLECT, RESULT}, received mask rcvd[2:0], latched bits vbits[2:0], result register, timeout flag, 4-bit round counter cnt.
- Reset (reset=0): state COLLECT, rcvd=000, vbits=000, cnt=0. Outputs: vote_rdy=111, result_val=0, result=0, result_timeout=0.
- COLLECT:
  - vote_rdy[i] = ~rcvd[i]; result_val=0.
  - Every fire (vote_val[i] & vote_rdy[i]) sets rcvd[i] and loads vbits[i]=vote_bit[i].
  - Any subset of voters, including all three, may fire in the same cycle.
  - A voter that has already voted is not ready. Its vote_val is ignored and it cannot overwrite its earlier vote.
  - When rcvd | fires == 111: register result = maj(vbits merged with this cycle's fired bits), set timeout=0, go to RESULT.
- RESULT:
  - vote_rdy=000, result_val=1, result and result_timeout held stable.
  - On result_rdy=1: clear rcvd, vbits and cnt, go to COLLECT.
  - vote_rdy returns to 111 in the following cycle. A vote offered in the handoff cycle is not accepted.
- Majority function: out = (b0&b1) | (b1&b2) | (b0&b2). Any vote missing at timeout counts as 0.

## Timing
- Latency: if the final vote fires in cycle N, result_val=1 in cycle N+1.
- Best-case throughput: 1 round per 2 cycles (all votes in one cycle, result consumed immediately).
- result_val stays high until the cycle in which result_rdy=1. It falls in the next cycle.
- result_rdy while in COLLECT is ignored.
- reset=0 mid-round or during RESULT discards all latched votes and any pending result. No result is emitted for the aborted round.

## Configuration
- VOTE_ROUND_TIMEOUT_EN defined:
  - cnt loads 1 on the cycle the first vote of a round fires, then increments by 1 each cycle while in COLLECT.
  - If the round is still incomplete when cnt == p_timeout, i.e. p_timeout cycles after first-vote cycle F:
    - Register result from vbits with missing votes as 0.
    - Set timeout=1 and go to RESULT.
    - result_val rises in cycle F+p_timeout+1.
  - Completion and timeout in the same cycle: completion wins; result includes the fired votes and result_timeout=0.
  - No vote in a round means no timeout; the round waits indefinitely.
- Undefined: cnt and the timeout logic are removed, result_timeout is tied to 0, and rounds wait indefinitely for all three votes.

## Test plan
- Reset: hold reset=0 with vote_val=111 -> vote_rdy=111, result_val=0, result=0. Release; the first rising edge accepts all votes.
- Simultaneous votes: vote_val=111, vote_bit=011 in one cycle -> next cycle result_val=1, result=1, vote_rdy=000. Repeat with bits 001, 000 and 111 -> result 0, 0, 1.
- Staggered votes with a duplicate attempt:
  - Voter 0 votes 1 in cycle 0.
  - Voter 0 retries with 0 in cycle 1 -> not accepted (vote_rdy[0]=0).
  - Voter 2 votes 0 in cycle 2; voter 1 votes 1 in cycle 4.
  - Expected: result_val=1 in cycle 5, result=1.
- Backpressure: hold result_rdy=0 for 5 cycles with new vote_val asserted -> result stable, vote_rdy=000. Raise result_rdy -> next cycle result_val=0, vote_rdy=111.
- Timeout (VOTE_ROUND_TIMEOUT_EN, p_timeout=4): only voters 0 and 1 vote 1 in cycle 0 -> result_val=1 in cycle 5, result=1, result_timeout=1. Repeat with bits 1,0 -> result=0.
- Timeout race and mid-round reset:
  - Timeout race: the third vote fires exactly in the timeout cycle -> result_timeout=0 and the vote is counted.
  - Mid-round reset: assert reset after 2 votes -> vote_rdy=111 and a fresh round, with no stale result.
